wb_data_ram: RTL and testbench

WB_DATA_RAM -- requirements
Module: wb_data_ram

---
 rtl/wb_data_ram.sv | 63 ++++++
 tb/tb_wb_data_ram.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/wb_data_ram.sv
// wb_data_ram: Wishbone-slave 32-bit data RAM with byte lanes, optional wait states and error termination
// Ports: clk, rst (sync, active-low); wb_cyc_i/wb_stb_i/wb_we_i/wb_adr_i(byte)/wb_sel_i/wb_dat_i request;
//        wb_dat_o read data (0 unless read ack), wb_ack_o/wb_err_o one-cycle termination pulses.
// Macro WB_DATA_RAM_WAIT_STATE_EN: inserts WAIT_CYCLES wait states before the termination pulse.
module wb_data_ram #(
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic req, bad, we_l, err_l;
  logic [ADDR_W-1:0] adr_l;
  logic [3:0] sel_l;
  logic [31:0] dat_l;
  logic [31:0] mem [2**ADDR_W];
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 1..15");
  end
  assign req = wb_cyc_i && wb_stb_i;
  // shift rather than slice so the out-of-range test stays legal for any ADDR_W
  assign bad = (wb_adr_i[1:0] != 2'b0) || ((wb_adr_i >> (ADDR_W + 2)) != 32'b0);
`ifdef WB_DATA_RAM_WAIT_STATE_EN
  logic [3:0] cnt;
  always_comb next = state == IDLE ? (req ? WAIT : IDLE) :
                     state == WAIT ? (!wb_cyc_i ? IDLE : cnt == 4'd1 ? RESP : WAIT) : IDLE;
  // reloaded every idle cycle, so it holds WAIT_CYCLES on entry to WAIT
  always_ff @(posedge clk)
    if (!rst) cnt <= 4'd0;
    else cnt <= state == IDLE ? 4'(WAIT_CYCLES) : cnt - 4'd1;
`else
  always_comb next = state == IDLE && req ? RESP : IDLE;
`endif
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk)
    if (state == IDLE && req) begin
      adr_l <= wb_adr_i[ADDR_W+1:2];
      we_l  <= wb_we_i;
      err_l <= bad;
      sel_l <= wb_sel_i;
      dat_l <= wb_dat_i;
    end
  always_ff @(posedge clk)
    if (rst && state == RESP && we_l && !err_l)
      for (int i = 0; i < 4; i++)
        if (sel_l[i]) mem[adr_l][8*i +: 8] <= dat_l[8*i +: 8];
  assign wb_ack_o = state == RESP && !err_l;
  assign wb_err_o = state == RESP && err_l;
  assign wb_dat_o = wb_ack_o && !we_l ? mem[adr_l] : 32'b0;
endmodule

// File: tb/tb_wb_data_ram.sv
// tb_wb_data_ram: randomized scoreboard bench for wb_data_ram against a word-array reference model
module tb_wb_data_ram;
  localparam int AW = 10;
  localparam int WC = 2;
`ifdef WB_DATA_RAM_WAIT_STATE_EN
  localparam int D = WC;
  localparam bit WS = 1'b1;
`else
  localparam int D = 0;
  localparam bit WS = 1'b0;
`endif
  localparam int P = D + 2;
  logic clk = 1'b0, rst = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0] wb_sel_i = '0;
  logic wb_ack_o, wb_err_o;
  typedef struct {bit err; bit chk; logic [31:0] dat; int cyc;} exp_t;
  exp_t q[$];
  logic [31:0] mdl [32];
  int cyc_n = 0, n_tests = 0, n_fail = 0;
  bit mon_en = 1'b0;

  wb_data_ram #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic bit is_err(input logic [31:0] a);
    return a[1:0] != 2'b0 || a >= (32'd1 << (AW + 2));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(negedge clk)
    if (mon_en) begin
      if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin : pop
        exp_t x;
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: ack=%b err=%b at cycle %0d, expected no pulse", wb_ack_o, wb_err_o, cyc_n);
        end else begin
          x = q.pop_front();
          if (wb_ack_o !== !x.err || wb_err_o !== x.err || cyc_n != x.cyc ||
              ((x.err || x.chk) && wb_dat_o !== x.dat)) begin
            n_fail++;
            $display("FAIL response: ack=%b err=%b dat=%h cycle=%0d expected ack=%b err=%b dat=%h cycle=%0d",
                     wb_ack_o, wb_err_o, wb_dat_o, cyc_n, !x.err, x.err, x.dat, x.cyc);
          end
        end
      end else chk("dat_idle", wb_dat_o, 32'h0);
    end

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat, input int mode);
    int e;
    bit er;
    logic [4:0] w;
    er = is_err(adr);
    w = adr[6:2];
    e = cyc_n + 1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    // mode 1 drops cyc, mode 2 pulses reset, one cycle after acceptance
    if (!(WS && mode != 0)) begin
      q.push_back(exp_t'{err: er, chk: !we && !er, dat: er ? 32'h0 : mdl[w], cyc: e + D});
      if (we && !er && mode != 2)
        for (int i = 0; i < 4; i++) if (sel[i]) mdl[w][8*i +: 8] = dat[8*i +: 8];
    end
    @(posedge clk); #1;
    wb_stb_i = 1'b0; wb_we_i = 1'($urandom); wb_adr_i = $urandom; wb_sel_i = 4'($urandom); wb_dat_i = $urandom;
    if (mode == 1) wb_cyc_i = 1'b0;
    if (mode == 2) begin
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ack", {31'b0, wb_ack_o}, 32'h0);
      chk("rst_err", {31'b0, wb_err_o}, 32'h0);
      chk("rst_dat", wb_dat_o, 32'h0);
      rst = 1'b1;
    end else begin
      repeat (D + 1) @(posedge clk);
      #1;
    end
    wb_cyc_i = 1'b0;
  endtask

  task automatic burst(input logic [31:0] adr, input int n);
    int e;
    e = cyc_n + 1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr; wb_sel_i = 4'h0;
    for (int k = 0; k < n; k++)
      q.push_back(exp_t'{err: 1'b0, chk: 1'b1, dat: mdl[adr[6:2]], cyc: e + k * P + D});
    repeat ((n - 1) * P + D + 2) @(posedge clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", {31'b0, wb_ack_o}, 32'h0);
    chk("reset_err", {31'b0, wb_err_o}, 32'h0);
    chk("reset_dat", wb_dat_o, 32'h0);
    rst = 1'b1;
    mon_en = 1'b1;
    for (int w = 0; w < 32; w++) xfer(1'b1, 32'(w * 4), 4'hF, $urandom, 0);
    xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    xfer(1'b0, 32'h10, 4'hF, 32'h0, 0);
    xfer(1'b1, 32'h20, 4'hF, 32'h11223344, 0);
    xfer(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 0);
    xfer(1'b0, 32'h20, 4'h3, 32'h0, 0);
    xfer(1'b0, 32'h22, 4'hF, 32'h0, 0);
    xfer(1'b0, 32'h1000, 4'hF, 32'h0, 0);
    xfer(1'b1, 32'h22, 4'hF, 32'hFFFFFFFF, 0);
    xfer(1'b1, 32'h30, 4'hF, 32'h5, 1);
    xfer(1'b0, 32'h30, 4'hF, 32'h0, 0);
    burst(32'h10, 4);
    xfer(1'b1, 32'h34, 4'hF, 32'hCAFEF00D, 2);
    xfer(1'b0, 32'h34, 4'hF, 32'h0, 0);
    for (int n = 0; n < 300; n++) begin
      int r, m;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = r == 0 ? {25'($urandom), 5'($urandom), 2'($urandom_range(1, 3))} :
          r == 1 ? ($urandom | 32'h1000) : {25'b0, 5'($urandom), 2'b0};
      r = $urandom_range(0, 9);
      m = r < 8 ? 0 : r == 8 ? 1 : 2;
      if ($urandom_range(0, 19) == 0) burst({25'b0, 5'($urandom), 2'b0}, $urandom_range(2, 4));
      else xfer(1'($urandom), a, 4'($urandom), $urandom, m);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("pending_responses", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
